// File: rtl/fast_8n1_uart_core.sv
// Full-duplex 8N1 UART engine: independent transmitter and receiver on one clock.
// Host side uses a LOAD_OK/TX_LOAD handshake for TX and a one-cycle strobe for RX.
module fast_8n1_uart_core #(
  parameter int unsigned SYSCLK_F = 24000000,
  parameter int unsigned BYTE_W   = 8,
  parameter int unsigned BAUDRATE = 500000
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              TX_LOAD,
  input  logic [BYTE_W-1:0] TX_DATA,
  output logic              LOAD_OK,
  output logic              TX_LINE,
  input  logic              rx_en,
  input  logic              RX_LINE,
  output logic [BYTE_W-1:0] RX_DATA,
  output logic              DATA_RDY_STROBE
);

  localparam int unsigned CLKS_PER_BIT = SYSCLK_F / BAUDRATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BW           = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BYTE_W - 1);

  typedef enum logic [1:0] {TXS_IDLE, TXS_START, TXS_DATA, TXS_STOP} tx_state_t;
  typedef enum logic [2:0] {RXS_IDLE, RXS_START, RXS_DATA, RXS_STOP, RXS_WAIT_HIGH} rx_state_t;

  tx_state_t         r_tx_state;
  logic              r_tx_line;
  logic              r_load_ok;
  logic [BYTE_W-1:0] r_tx_shift;
  logic [CW-1:0]     r_tx_cnt;
  logic [BW-1:0]     r_tx_bit;

  rx_state_t         r_rx_state;
  logic              r_rx_meta;
  logic              r_rxs;
  logic              r_rxs_d;
  logic [BYTE_W-1:0] r_rx_shift;
  logic [CW-1:0]     r_rx_cnt;
  logic [BW-1:0]     r_rx_bit;
  logic [BYTE_W-1:0] r_rx_data;
  logic              r_rx_strobe;

  logic              w_rx_fall;

  assign LOAD_OK         = r_load_ok;
  assign TX_LINE         = r_tx_line;
  assign RX_DATA         = r_rx_data;
  assign DATA_RDY_STROBE = r_rx_strobe;
  assign w_rx_fall       = r_rxs_d & ~r_rxs;

  // Transmitter: serialises start bit, LSB-first data and stop bit; LOAD_OK paces the host.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_tx_state <= TXS_IDLE;
      r_tx_line  <= 1'b1;
      r_load_ok  <= 1'b0;
      r_tx_shift <= '0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
    end else begin
      case (r_tx_state)
        TXS_IDLE: begin
          r_tx_line <= 1'b1;
          r_tx_cnt  <= '0;
          r_tx_bit  <= '0;
          if (r_load_ok && TX_LOAD) begin
            r_tx_shift <= TX_DATA;
            r_load_ok  <= 1'b0;
            r_tx_line  <= 1'b0;
            r_tx_state <= TXS_START;
          end else begin
            r_load_ok <= tx_en;
          end
        end
        TXS_START: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_line  <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_state <= TXS_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        TXS_DATA: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == BIT_LAST) begin
              r_tx_line  <= 1'b1;
              r_tx_state <= TXS_STOP;
            end else begin
              r_tx_bit   <= r_tx_bit + BW'(1);
              r_tx_line  <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        TXS_STOP: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_state <= TXS_IDLE;
            r_load_ok  <= tx_en;
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        default: r_tx_state <= TXS_IDLE;
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous RX pin, plus one delay stage for edge detection.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_rx_meta <= 1'b0;
      r_rxs     <= 1'b0;
      r_rxs_d   <= 1'b0;
    end else begin
      r_rx_meta <= RX_LINE;
      r_rxs     <= r_rx_meta;
      r_rxs_d   <= r_rxs;
    end
  end

  // Receiver: start-edge hunt, mid-bit sampling, stop-bit validation and one-cycle strobe.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_rx_state  <= RXS_IDLE;
      r_rx_shift  <= '0;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_data   <= '0;
      r_rx_strobe <= 1'b0;
    end else begin
      r_rx_strobe <= 1'b0;
      if (!rx_en) begin
        r_rx_state <= RXS_IDLE;
        r_rx_cnt   <= '0;
        r_rx_bit   <= '0;
      end else begin
        case (r_rx_state)
          RXS_IDLE: begin
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            if (w_rx_fall) r_rx_state <= RXS_START;
          end
          RXS_START: begin
            if (r_rx_cnt == HALF_LAST) begin
              r_rx_cnt   <= '0;
              r_rx_state <= r_rxs ? RXS_IDLE : RXS_DATA;
            end else begin
              r_rx_cnt <= r_rx_cnt + CW'(1);
            end
          end
          RXS_DATA: begin
            if (r_rx_cnt == CNT_LAST) begin
              r_rx_cnt   <= '0;
              r_rx_shift <= {r_rxs, r_rx_shift[BYTE_W-1:1]};
              if (r_rx_bit == BIT_LAST) r_rx_state <= RXS_STOP;
              else                      r_rx_bit   <= r_rx_bit + BW'(1);
            end else begin
              r_rx_cnt <= r_rx_cnt + CW'(1);
            end
          end
          RXS_STOP: begin
            if (r_rx_cnt == CNT_LAST) begin
              r_rx_cnt <= '0;
              if (r_rxs) begin
                r_rx_data   <= r_rx_shift;
                r_rx_strobe <= 1'b1;
                r_rx_state  <= RXS_IDLE;
              end else begin
                r_rx_state <= RXS_WAIT_HIGH;
              end
            end else begin
              r_rx_cnt <= r_rx_cnt + CW'(1);
            end
          end
          RXS_WAIT_HIGH: begin
            if (r_rxs) r_rx_state <= RXS_IDLE;
          end
          default: r_rx_state <= RXS_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fast_8n1_uart_core.sv
// Self-checking bench for fast_8n1_uart_core at default parameters (48 clocks per bit).
module tb_fast_8n1_uart_core;

  localparam int CPB = 48;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst;
  logic       tx_en;
  logic       tx_load;
  logic [7:0] tx_data;
  logic       load_ok;
  logic       tx_line;
  logic       rx_en;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_strobe;

  logic       loop_sel;
  logic       rx_drv;

  int checks   = 0;
  int failures = 0;
  int strobe_cnt = 0;
  logic [7:0] sb[$];
  logic [7:0] last_rx;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp_rx;
    bit         mid_load;
  } vec_t;

  vec_t vecs[6];

  assign rx_line = loop_sel ? tx_line : rx_drv;

  fast_8n1_uart_core #(
    .SYSCLK_F (24000000),
    .BYTE_W   (8),
    .BAUDRATE (500000)
  ) dut (
    .sys_clk         (clk),
    .rst             (rst),
    .tx_en           (tx_en),
    .TX_LOAD         (tx_load),
    .TX_DATA         (tx_data),
    .LOAD_OK         (load_ok),
    .TX_LINE         (tx_line),
    .rx_en           (rx_en),
    .RX_LINE         (rx_line),
    .RX_DATA         (rx_data),
    .DATA_RDY_STROBE (rx_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && rx_strobe === 1'b1) begin
      strobe_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {24'd0, rx_data}, 32'hFFFF_FFFF);
      end else begin
        chk("rx_data_scoreboard", {24'd0, rx_data}, {24'd0, sb.pop_front()});
      end
    end
  end

  // Sends one byte from the current negedge (LOAD_OK must be 1) and checks the waveform.
  task automatic tx_frame(input logic [7:0] b, input logic [7:0] exp_rx, input bit mid_load);
    logic [9:0] pat;
    int bad[10];
    int lo_bad;
    int s_at;
    int base;
    pat = {1'b1, b, 1'b0};
    foreach (bad[k]) bad[k] = 0;
    lo_bad = 0;
    s_at = -1;
    chk("tx_load_ok_before", {31'd0, load_ok}, 32'd1);
    tx_data = b;
    tx_load = 1'b1;
    sb.push_back(exp_rx);
    base = strobe_cnt;
    @(negedge clk);
    tx_load = 1'b0;
    for (int s = 0; s < FRAME; s++) begin
      if (tx_line !== pat[s / CPB]) bad[s / CPB]++;
      if (load_ok !== 1'b0) lo_bad++;
      if (rx_strobe === 1'b1) s_at = s;
      if (mid_load && s == 240) begin
        tx_load = 1'b1;
        tx_data = 8'hFF;
      end
      if (mid_load && s == 241) tx_load = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) chk($sformatf("tx_bit%0d_of_%0h", k, b), bad[k], 0);
    chk("tx_load_ok_low_frame", lo_bad, 0);
    chk("tx_load_ok_after", {31'd0, load_ok}, 32'd1);
    chk("tx_line_idle_after", {31'd0, tx_line}, 32'd1);
    chk("loop_strobe_count", strobe_cnt - base, 1);
    chk("loop_strobe_timing", (s_at >= 457 && s_at <= 461) ? 1 : 0, 1);
  endtask

  task automatic rx_hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv = v;
      @(negedge clk);
    end
  endtask

  // Drives one frame on RX_LINE with the given stop-bit value, then 40 idle cycles.
  task automatic rx_send(input logic [7:0] b, input logic stop);
    int base;
    base = strobe_cnt;
    if (stop) begin
      sb.push_back(b);
      last_rx = b;
    end
    rx_hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) rx_hold(b[i], CPB);
    rx_hold(stop, CPB);
    rx_hold(1'b1, 40);
    chk($sformatf("rx_strobes_%0h_stop%0d", b, stop), strobe_cnt - base, stop ? 1 : 0);
    chk($sformatf("rx_data_after_%0h", b), {24'd0, rx_data}, {24'd0, last_rx});
  endtask

  initial begin
    int base;
    int waited;
    bit idle_bad;

    vecs[0] = '{tx: 8'h41, exp_rx: 8'h41, mid_load: 1'b0};
    vecs[1] = '{tx: 8'h42, exp_rx: 8'h42, mid_load: 1'b1};
    vecs[2] = '{tx: 8'h53, exp_rx: 8'h53, mid_load: 1'b0};
    vecs[3] = '{tx: 8'h00, exp_rx: 8'h00, mid_load: 1'b1};
    vecs[4] = '{tx: 8'hFF, exp_rx: 8'hFF, mid_load: 1'b0};
    vecs[5] = '{tx: 8'hA5, exp_rx: 8'hA5, mid_load: 1'b0};

    rst = 1'b1;
    tx_en = 1'b0;
    rx_en = 1'b0;
    tx_load = 1'b0;
    tx_data = 8'h00;
    loop_sel = 1'b1;
    rx_drv = 1'b1;
    last_rx = 8'h00;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx_line", {31'd0, tx_line}, 32'd1);
      chk("rst_load_ok", {31'd0, load_ok}, 32'd0);
    end
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_strobe", {31'd0, rx_strobe}, 32'd0);
    rst = 1'b0;
    tx_en = 1'b1;
    rx_en = 1'b1;

    waited = 0;
    while (load_ok !== 1'b1 && waited < 3) begin
      @(negedge clk);
      waited++;
      chk("post_rst_tx_line", {31'd0, tx_line}, 32'd1);
    end
    chk("load_ok_rise_within_2", (load_ok === 1'b1 && waited <= 2) ? 1 : 0, 1);

    // Back-to-back loopback frames, each reloaded on the cycle LOAD_OK rises
    if (load_ok === 1'b1) begin
      for (int v = 0; v < 6; v++) tx_frame(vecs[v].tx, vecs[v].exp_rx, vecs[v].mid_load);
    end
    last_rx = vecs[5].exp_rx;

    // Ignored mid-frame loads must not start another frame
    idle_bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tx_line !== 1'b1 || load_ok !== 1'b1) idle_bad = 1'b1;
      @(negedge clk);
    end
    chk("no_queued_frame", {31'd0, idle_bad}, 32'd0);

    // LOAD_OK follows tx_en while idle
    tx_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("load_ok_txen_low", {31'd0, load_ok}, 32'd0);
    tx_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("load_ok_txen_high", {31'd0, load_ok}, 32'd1);

    // Direct RX stimulus
    rx_drv = 1'b1;
    loop_sel = 1'b0;
    rx_hold(1'b1, 20);

    base = strobe_cnt;
    rx_hold(1'b0, 10);
    rx_hold(1'b1, 100);
    chk("glitch_no_strobe", strobe_cnt - base, 0);
    rx_send(8'h0A, 1'b1);

    rx_send(8'hFF, 1'b0);
    rx_hold(1'b1, 20);
    rx_send(8'h55, 1'b1);

    // rx_en drop mid-frame aborts it
    base = strobe_cnt;
    rx_hold(1'b0, 100);
    rx_en = 1'b0;
    rx_hold(1'b0, 5);
    rx_en = 1'b1;
    rx_hold(1'b0, 95);
    rx_hold(1'b1, 600);
    chk("abort_no_strobe", strobe_cnt - base, 0);
    chk("abort_rx_data_kept", {24'd0, rx_data}, 32'h55);

    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
